// File: rtl/cca_scan_ctrl.sv
// Raster-scan sequencer for the dual-lane CCL datapath: walks the frame one pixel pair per
// accepted cycle, issues segmentation/label reads and writes labels back two stages later.
module cca_scan_ctrl #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 48,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] seg_rd_addr,
    output logic              seg_rd_en,
    output logic [ADDR_W-1:0] up_rd_addr,
    output logic              up_valid,
    output logic              left_valid,
    output logic              cca_enable,
    output logic [ADDR_W-1:0] lbl_wr_addr,
    output logic              lbl_wr_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int PAIRS = IMG_W / 2;
    localparam int TOTAL = PAIRS * IMG_H;
    localparam int COL_W = $clog2(PAIRS);
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] PAIRS_A   = ADDR_W'(PAIRS);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(PAIRS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              vld_p1_q, vld_p1_d;
    logic              vld_p2_q, vld_p2_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    // Stage payloads carry no meaning while their valid bit is low, so they skip reset.
    logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;
    logic [ADDR_W-1:0] addr_p2_q, addr_p2_d;
    logic              up_p1_q, up_p1_d;
    logic              left_p1_q, left_p1_d;

    logic scanning;
    logic issue;
    logic wr_fire;

    always_comb begin
        scanning = (state_q == SCAN);
        issue    = scanning && mem_ready;
        wr_fire  = vld_p2_q && mem_ready;
    end

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        col_d        = col_q;
        row_d        = row_q;
        vld_p1_d     = vld_p1_q;
        vld_p2_d     = vld_p2_q;
        addr_p1_d    = addr_p1_q;
        addr_p2_d    = addr_p2_q;
        up_p1_d      = up_p1_q;
        left_p1_d    = left_p1_q;

        // p0 -> p1 -> p2: the whole pipe shifts only on a granted memory cycle
        if (mem_ready) begin
            vld_p1_d  = issue;
            addr_p1_d = rd_ptr_q;
            up_p1_d   = (row_q != '0);
            left_p1_d = (col_q != '0);
            vld_p2_d  = vld_p1_q;
            addr_p2_d = addr_p1_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SCAN;
                    rd_ptr_d = '0;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
            SCAN: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (rd_ptr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (wr_fire && (addr_p2_q == LAST_ADDR)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_p1_q <= addr_p1_d;
        addr_p2_q <= addr_p2_d;
        up_p1_q   <= up_p1_d;
        left_p1_q <= left_p1_d;
    end

    // Address buses are forced to zero whenever their stage is empty so idle/reset reads as 0.
    always_comb begin
        seg_rd_en   = issue;
        seg_rd_addr = scanning ? rd_ptr_q : '0;
        up_rd_addr  = scanning ? (rd_ptr_q - PAIRS_A) : '0;
        up_valid    = vld_p1_q && up_p1_q;
        left_valid  = vld_p1_q && left_p1_q;
        cca_enable  = vld_p1_q && mem_ready;
        lbl_wr_en   = wr_fire;
        lbl_wr_addr = vld_p2_q ? addr_p2_q : '0;
        busy        = busy_q;
        frame_done  = frame_done_q;
    end

endmodule

// File: tb/tb_cca_scan_ctrl.sv
// Bench for cca_scan_ctrl: three geometries (4x2, 64x48, 8x1) driven in turn and compared
// each cycle against a model derived from counting granted memory cycles since start.
`timescale 1ns/1ps
module tb_cca_scan_ctrl;

    localparam int AW   = 11;
    localparam int MASK = (1 << AW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic mem_ready;
    int   sel;

    logic [AW-1:0] seg_addr_w [3];
    logic [AW-1:0] up_addr_w  [3];
    logic [AW-1:0] wr_addr_w  [3];
    logic          seg_en_w   [3];
    logic          up_v_w     [3];
    logic          left_v_w   [3];
    logic          cca_en_w   [3];
    logic          wr_en_w    [3];
    logic          busy_w     [3];
    logic          done_w     [3];

    int checks = 0;
    int errors = 0;

    cca_scan_ctrl #(.IMG_W(4), .IMG_H(2), .ADDR_W(AW)) u_small (
        .clk(clk), .reset(reset), .start(start && (sel == 0)), .mem_ready(mem_ready),
        .seg_rd_addr(seg_addr_w[0]), .seg_rd_en(seg_en_w[0]), .up_rd_addr(up_addr_w[0]),
        .up_valid(up_v_w[0]), .left_valid(left_v_w[0]), .cca_enable(cca_en_w[0]),
        .lbl_wr_addr(wr_addr_w[0]), .lbl_wr_en(wr_en_w[0]), .busy(busy_w[0]),
        .frame_done(done_w[0])
    );

    cca_scan_ctrl #(.IMG_W(64), .IMG_H(48), .ADDR_W(AW)) u_big (
        .clk(clk), .reset(reset), .start(start && (sel == 1)), .mem_ready(mem_ready),
        .seg_rd_addr(seg_addr_w[1]), .seg_rd_en(seg_en_w[1]), .up_rd_addr(up_addr_w[1]),
        .up_valid(up_v_w[1]), .left_valid(left_v_w[1]), .cca_enable(cca_en_w[1]),
        .lbl_wr_addr(wr_addr_w[1]), .lbl_wr_en(wr_en_w[1]), .busy(busy_w[1]),
        .frame_done(done_w[1])
    );

    cca_scan_ctrl #(.IMG_W(8), .IMG_H(1), .ADDR_W(AW)) u_row (
        .clk(clk), .reset(reset), .start(start && (sel == 2)), .mem_ready(mem_ready),
        .seg_rd_addr(seg_addr_w[2]), .seg_rd_en(seg_en_w[2]), .up_rd_addr(up_addr_w[2]),
        .up_valid(up_v_w[2]), .left_valid(left_v_w[2]), .cca_enable(cca_en_w[2]),
        .lbl_wr_addr(wr_addr_w[2]), .lbl_wr_en(wr_en_w[2]), .busy(busy_w[2]),
        .frame_done(done_w[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int s, input string tag);
        chk(tag, 64'({seg_addr_w[s], up_addr_w[s], wr_addr_w[s], seg_en_w[s], up_v_w[s],
                      left_v_w[s], cca_en_w[s], wr_en_w[s], busy_w[s], done_w[s]}), 64'(0));
    endtask

    // The n-th granted cycle of a frame issues pair n; pair k sits in the data-valid stage
    // until grant k+1 and is written on grant k+2; frame_done follows grant TOTAL+1.
    task automatic run_frame(input int s, input int pairs, input int total, input int mode,
                             input bit extra, input int abort_c);
        int n       = 0;
        int d       = 1 << 30;
        int c       = 0;
        int wr_cnt  = 0;
        int done_n  = 0;
        int last_wr = -1;
        int done_c  = -1;
        bit r, scan, v1, v2;
        int p1, p2;
        sel = s;
        @(posedge clk); #1;
        start     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("idle_before_start", 64'(busy_w[s]), 64'(0));
        while (c <= d + 1) begin
            @(posedge clk); #1;
            case (mode)
                0:       r = 1'b1;
                1:       r = !(c >= 2 && c <= 4);
                default: r = (c > 4 * total) || ($urandom_range(0, 3) != 0);
            endcase
            mem_ready = r;
            start     = extra && (c <= d) && ((c == d) || ($urandom_range(0, 5) == 0));
            @(negedge clk);
            scan = (n < total);
            p1   = n - 1;
            p2   = n - 2;
            v1   = (n >= 1) && (n <= total);
            v2   = (n >= 2) && (n <= total + 1);
            chk("seg_rd_en", 64'(seg_en_w[s]), 64'(scan && r));
            if (scan) chk("seg_rd_addr", 64'(seg_addr_w[s]), 64'(n));
            if (scan && n >= pairs) chk("up_rd_addr", 64'(up_addr_w[s]), 64'((n - pairs) & MASK));
            chk("up_valid", 64'(up_v_w[s]), 64'(v1 && ((p1 / pairs) != 0)));
            chk("left_valid", 64'(left_v_w[s]), 64'(v1 && ((p1 % pairs) != 0)));
            chk("cca_enable", 64'(cca_en_w[s]), 64'(v1 && r));
            chk("lbl_wr_en", 64'(wr_en_w[s]), 64'(v2 && r));
            if (v2) chk("lbl_wr_addr", 64'(wr_addr_w[s]), 64'(p2));
            chk("busy", 64'(busy_w[s]), 64'(c <= d));
            chk("frame_done", 64'(done_w[s]), 64'(c == d));
            if (wr_en_w[s]) begin
                wr_cnt++;
                last_wr = int'(wr_addr_w[s]);
            end
            if (done_w[s]) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (c == abort_c) begin
                start = 1'b0;
                reset = 1'b0;
                #1;
                chk_idle(s, "reset_async_zero");
                repeat (3) begin
                    @(negedge clk);
                    chk_idle(s, "reset_held_zero");
                end
                reset = 1'b1;
                return;
            end
            if (r) begin
                if (n == total + 1) d = c + 1;
                n++;
            end
            c++;
            if (c >= 30000) begin
                chk("frame_timeout", 64'(c), 64'(0));
                break;
            end
        end
        start = 1'b0;
        chk("wr_count", 64'(wr_cnt), 64'(total));
        chk("last_wr_addr", 64'(last_wr), 64'(total - 1));
        chk("done_count", 64'(done_n), 64'(1));
        chk("done_cycle", 64'(done_c), 64'(mode == 0 ? total + 2 : (mode == 1 ? total + 5 : d)));
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b0;
        sel       = 0;
        #1;
        for (int i = 0; i < 3; i++) chk_idle(i, "reset_state");
        mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk_idle(i, "reset_state_ready");
        @(negedge clk);
        reset = 1'b1;

        run_frame(0, 2, 4, 0, 1'b0, -1);
        run_frame(0, 2, 4, 1, 1'b0, -1);
        run_frame(0, 2, 4, 0, 1'b0, 3);
        run_frame(0, 2, 4, 0, 1'b0, -1);
        run_frame(0, 2, 4, 0, 1'b1, -1);
        run_frame(0, 2, 4, 2, 1'b1, -1);
        run_frame(2, 4, 4, 2, 1'b1, -1);
        run_frame(2, 4, 4, 1, 1'b0, -1);
        run_frame(1, 32, 1536, 0, 1'b0, -1);
        run_frame(1, 32, 1536, 2, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
